// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage.
//
// Owns the PC and issues word-aligned reads to instruction memory. It hands
// the instruction, its pc, pc+4 and the next fetch pc to the IF/ID register.
// A freeze that arrives with a memory response parks the word in a one-entry
// skid buffer (HOLD). Redirects re-aim the PC. An access that was already
// outstanding is drained and discarded (DROP). A halt stops fetching until
// reset (HALT).
//
// Optional feature: define FETCH_PERF_EN to add the fetch_count and
// stall_count performance counters.
//
// Ports:
//   CLK, RST                  clock (rising edge), async active-high reset
//   imem_ren / imem_addr      read request and word-aligned address
//   imem_wait / imem_load     memory busy flag and returned instruction word
//   freeze                    IF/ID holding; no hand-over this cycle
//   redirect / redirect_pc    control transfer from later stages
//   halt                      stop fetching (sticky until reset)
//   imem_load_i, pc_i,        instruction fields for IF/ID
//   pc_p4_i, nxt_pc_i
//   ihit                      fields valid; IF/ID captures on ihit & ~freeze
//   fetch_count, stall_count  (FETCH_PERF_EN only) hit / memory-stall counters
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_ren,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_wait,
  input  logic [ADDR_W-1:0] imem_load,
  input  logic              freeze,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_load_i,
  output logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_p4_i,
  output logic [ADDR_W-1:0] nxt_pc_i,
  output logic              ihit
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] skid_word_q, skid_word_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0] skid_pc_p4_q, skid_pc_p4_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic              halt_pend_q, halt_pend_d;

  logic [ADDR_W-1:0] pc_p4;
  logic [ADDR_W-1:0] redirect_pc_al;

  assign pc_p4          = pc_q + ADDR_W'(4);
  // Low two bits of the redirect target are ignored: fetches are word aligned.
  assign redirect_pc_al = redirect_pc & ~ADDR_W'(3);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_FETCH;
      pc_q          <= PC_INIT;
      skid_word_q   <= '0;
      skid_pc_q     <= '0;
      skid_pc_p4_q  <= '0;
      drop_addr_q   <= '0;
      halt_pend_q   <= 1'b0;
`ifdef FETCH_PERF_EN
      fetch_count_q <= '0;
      stall_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_word_q   <= skid_word_d;
      skid_pc_q     <= skid_pc_d;
      skid_pc_p4_q  <= skid_pc_p4_d;
      drop_addr_q   <= drop_addr_d;
      halt_pend_q   <= halt_pend_d;
`ifdef FETCH_PERF_EN
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_word_d  = skid_word_q;
    skid_pc_d    = skid_pc_q;
    skid_pc_p4_d = skid_pc_p4_q;
    drop_addr_d  = drop_addr_q;
    halt_pend_d  = halt_pend_q;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          // Redirect wins; any response this cycle belongs to the old path.
          pc_d = redirect_pc_al;
          if (imem_wait) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
            halt_pend_d = halt;
          end else begin
            state_d = halt ? S_HALT : S_FETCH;
          end
        end else if (halt) begin
          if (imem_wait) begin
            // Let the memory finish before going quiet.
            state_d     = S_DROP;
            drop_addr_d = pc_q;
            halt_pend_d = 1'b1;
          end else begin
            state_d = S_HALT;
          end
        end else if (!imem_wait) begin
          pc_d = pc_p4;
          if (freeze) begin
            state_d      = S_HOLD;
            skid_word_d  = imem_load;
            skid_pc_d    = pc_q;
            skid_pc_p4_d = pc_p4;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc_al;
          state_d = halt ? S_HALT : S_FETCH;
        end else if (halt) begin
          state_d = S_HALT;
        end else if (!freeze) begin
          state_d = S_FETCH;
        end
      end

      S_DROP: begin
        if (redirect) pc_d = redirect_pc_al;
        if (halt) halt_pend_d = 1'b1;
        if (!imem_wait) state_d = (halt_pend_q || halt) ? S_HALT : S_FETCH;
      end

      default: begin
        // S_HALT: everything frozen until reset.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_ren    = 1'b0;
    imem_addr   = '0;
    imem_load_i = '0;
    pc_i        = '0;
    pc_p4_i     = '0;
    nxt_pc_i    = pc_d;
    ihit        = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_ren    = 1'b1;
        imem_addr   = pc_q;
        imem_load_i = imem_load;
        pc_i        = pc_q;
        pc_p4_i     = pc_p4;
        ihit        = !imem_wait && !freeze && !redirect && !halt;
      end
      S_HOLD: begin
        imem_load_i = skid_word_q;
        pc_i        = skid_pc_q;
        pc_p4_i     = skid_pc_p4_q;
        ihit        = !freeze && !redirect && !halt;
      end
      S_DROP: begin
        // Keep the abandoned request stable until memory acknowledges it.
        imem_ren  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: begin
      end
    endcase

    // Registers are already at their reset values; this also silences the
    // combinational pass-through paths while reset is held.
    if (RST) begin
      imem_ren    = 1'b0;
      imem_addr   = '0;
      imem_load_i = '0;
      pc_i        = '0;
      pc_p4_i     = '0;
      nxt_pc_i    = '0;
      ihit        = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (state_q != S_HALT) begin
      if (ihit && !freeze)      fetch_count_d = fetch_count_q + 32'd1;
      if (imem_ren && imem_wait) stall_count_d = stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit.
// Stimulus pushes expected {pc, pc+4} entries into a scoreboard queue; a
// monitor pops one entry per delivered instruction (ihit & ~freeze). Memory
// returns addr ^ 32'hC0DE_0000 and stalls a chosen address for slow_lat cycles.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        CLK;
  logic        RST = 1'b0;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_wait;
  logic [31:0] imem_load;
  logic        freeze;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_load_i;
  logic [31:0] pc_i;
  logic [31:0] pc_p4_i;
  logic [31:0] nxt_pc_i;
  logic        ihit;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_unit #(.ADDR_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_wait   (imem_wait),
    .imem_load   (imem_load),
    .freeze      (freeze),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_load_i (imem_load_i),
    .pc_i        (pc_i),
    .pc_p4_i     (pc_p4_i),
    .nxt_pc_i    (nxt_pc_i),
    .ihit        (ihit)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: one slow address, all others answer immediately.
  logic [31:0] slow_addr;
  int          slow_lat;
  int          wait_cnt = 0;

  assign imem_wait = imem_ren && (imem_addr == slow_addr) && (wait_cnt < slow_lat);
  assign imem_load = imem_addr ^ 32'hC0DE_0000;

  always @(posedge CLK) begin
    if (imem_ren && imem_wait) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  // Scoreboard
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] p4);
    exp_t e;
    e.pc = pc;
    e.p4 = p4;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST && ihit && !freeze) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ihit: got pc_i %h, expected no delivery (t=%0t)", pc_i, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc_i",     pc_i,        e.pc);
        chk("sb_pc_p4_i",  pc_p4_i,     e.p4);
        chk("sb_instr",    imem_load_i, e.pc ^ 32'hC0DE_0000);
        chk("sb_nxt_pc_i", nxt_pc_i,    e.p4);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    freeze      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    slow_addr   = 32'h20;
    slow_lat    = 2;
    #1 RST = 1'b1;

    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h8, 32'hC);
    push(32'hC, 32'h10);

    // Reset held
    tick(); tick(); #2;
    chk("rst_imem_ren",    {31'b0, imem_ren}, 32'd0);
    chk("rst_ihit",        {31'b0, ihit},     32'd0);
    chk("rst_imem_load_i", imem_load_i,       32'h0);
    chk("rst_pc_i",        pc_i,              32'h0);
    chk("rst_nxt_pc_i",    nxt_pc_i,          32'h0);

    // C0: first request right after release
    tick(); RST = 1'b0; #2;
    chk("c0_imem_ren",  {31'b0, imem_ren}, 32'd1);
    chk("c0_imem_addr", imem_addr,         32'h0);
    chk("c0_ihit",      {31'b0, ihit},     32'd1);
    tick(); tick(); tick();

    // C4..C6: freeze on response of 0x10
    tick(); freeze = 1'b1; #2;
    chk("frz_addr", imem_addr,     32'h10);
    chk("frz_ihit", {31'b0, ihit}, 32'd0);
    tick(); #2;
    chk("hold_ren",    {31'b0, imem_ren}, 32'd0);
    chk("hold_ihit1",  {31'b0, ihit},     32'd0);
    chk("hold_nxt_pc", nxt_pc_i,          32'h14);
    tick(); #2;
    chk("hold_ihit2", {31'b0, ihit}, 32'd0);
    push(32'h10, 32'h14);
    push(32'h14, 32'h18);
    push(32'h18, 32'h1C);
    push(32'h1C, 32'h20);
    tick(); freeze = 1'b0; #2;
    chk("unfrz_ihit", {31'b0, ihit},     32'd1);
    chk("unfrz_ren",  {31'b0, imem_ren}, 32'd0);
    tick(); #2;
    chk("after_hold_addr", imem_addr, 32'h14);
    tick(); tick();

    // C11: redirect in first wait cycle of 0x20
    tick(); redirect = 1'b1; redirect_pc = 32'h103; #2;
    chk("rdw_addr",   imem_addr,     32'h20);
    chk("rdw_ihit",   {31'b0, ihit}, 32'd0);
    chk("rdw_nxt_pc", nxt_pc_i,      32'h100);
    tick(); redirect = 1'b0; #2;
    chk("drop_ren",  {31'b0, imem_ren}, 32'd1);
    chk("drop_addr", imem_addr,         32'h20);
    chk("drop_ihit", {31'b0, ihit},     32'd0);
    tick(); #2;
    chk("drop_resp_addr", imem_addr,     32'h20);
    chk("drop_resp_ihit", {31'b0, ihit}, 32'd0);
    push(32'h100, 32'h104);
    push(32'h104, 32'h108);
    tick(); slow_addr = 32'h40; #2;
    chk("rd_new_addr", imem_addr,     32'h100);
    chk("rd_new_ihit", {31'b0, ihit}, 32'd1);
    tick();

    // Redirect with immediate response, then pc wrap
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #2;
    chk("rdz_ihit", {31'b0, ihit}, 32'd0);
    push(32'hFFFF_FFFC, 32'h0);
    push(32'h0, 32'h4);
    tick(); redirect = 1'b0; #2;
    chk("wrap_pc_p4", pc_p4_i, 32'h0);
    tick(); #2;
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Halt during outstanding access at 0x40
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #2;
    chk("rd40_ihit", {31'b0, ihit}, 32'd0);
    tick(); redirect = 1'b0; halt = 1'b1; #2;
    chk("halt_addr", imem_addr,     32'h40);
    chk("halt_ihit", {31'b0, ihit}, 32'd0);
    tick(); halt = 1'b0; #2;
    chk("hdrop_ren",  {31'b0, imem_ren}, 32'd1);
    chk("hdrop_addr", imem_addr,         32'h40);
    tick(); #2;
    chk("hdrop_resp_ihit", {31'b0, ihit}, 32'd0);
    tick(); #2;
    chk("halted_ren",  {31'b0, imem_ren}, 32'd0);
    chk("halted_ihit", {31'b0, ihit},     32'd0);
    tick(); redirect = 1'b1; redirect_pc = 32'h200; #2;
    chk("halted_rd_ren",  {31'b0, imem_ren}, 32'd0);
    chk("halted_rd_ihit", {31'b0, ihit},     32'd0);
    tick(); redirect = 1'b0; #2;
    chk("halted_after_rd_ren", {31'b0, imem_ren}, 32'd0);
    chk("halted_pc_frozen",    nxt_pc_i,          32'h40);

    // Reset restores PC_INIT; then 5 hits, 2 stall cycles, 1 frozen hit
    slow_addr = 32'h14;
    RST = 1'b1; #1;
    chk("arst_ren",  {31'b0, imem_ren}, 32'd0);
    chk("arst_ihit", {31'b0, ihit},     32'd0);
    push(32'h0,  32'h4);
    push(32'h4,  32'h8);
    push(32'h8,  32'hC);
    push(32'hC,  32'h10);
    push(32'h10, 32'h14);
    push(32'h14, 32'h18);
    push(32'h18, 32'h1C);
    tick(); tick();
    tick(); RST = 1'b0; #2;
    chk("rst2_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch0", fetch_count, 32'd0);
    chk("perf_stall0", stall_count, 32'd0);
`endif
    tick(); tick(); tick(); tick();
    tick(); #2;
    chk("stall_addr", imem_addr,     32'h14);
    chk("stall_ihit", {31'b0, ihit}, 32'd0);
    tick();
    tick(); freeze = 1'b1; #2;
    chk("perf_frz_ihit", {31'b0, ihit}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch5", fetch_count, 32'd5);
    chk("perf_stall2", stall_count, 32'd2);
`endif
    tick(); freeze = 1'b0; #2;
    chk("perf_deliver_ihit", {31'b0, ihit}, 32'd1);
    tick(); #2;
    chk("perf_next_addr", imem_addr, 32'h18);
`ifdef FETCH_PERF_EN
    chk("perf_fetch6", fetch_count, 32'd6);
    chk("perf_stall2b", stall_count, 32'd2);
`endif

    // Halt with a response completing the same cycle
    tick(); halt = 1'b1; #2;
    chk("halt_same_ihit", {31'b0, ihit}, 32'd0);
    tick(); halt = 1'b0; #2;
    chk("halt2_ren",  {31'b0, imem_ren}, 32'd0);
    chk("halt2_ihit", {31'b0, ihit},     32'd0);
    tick(); #2;
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
